dmem_arbiter: RTL and testbench
===============================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32, sets the byte-address width of the requester and memory ports.
REQ-002 Parameter DATA_W, default 32, sets the data word width.
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 rN_valid  input  1  requester N (N=0 core, N=1 debug loader) presents a request.
REQ-006 rN_ready  output  1  request of requester N is accepted this cycle.
REQ-007 rN_we  input  1  1 = store, 0 = load.
REQ-008 rN_addr  input  ADDR_W  byte address.
REQ-009 rN_wdata  input  DATA_W  store data.
REQ-010 rN_rvalid  output  1  one-cycle completion pulse for requester N.
REQ-011 rN_rdata  output  DATA_W  load data, valid while rN_rvalid=1.
REQ-012 rN_err  output  1  completion is a misaligned-access error, valid while rN_rvalid=1.
REQ-013 mem_en  output  1  memory access strobe.
REQ-014 mem_we  output  1  memory write enable, qualified by mem_en.
REQ-015 mem_addr  output  ADDR_W  memory byte address.
REQ-016 mem_wdata  output  DATA_W  memory write data.
REQ-017 mem_rdata  input  DATA_W  memory read data, valid the cycle after mem_en with mem_we=0.

Function
REQ-018 FSM SHALL have the states IDLE, ACCESS and RESP.
REQ-019 In IDLE, the arbiter SHALL assert rN_ready combinationally for exactly one valid requester (the winner) and none otherwise.
REQ-020 On acceptance, the arbiter SHALL latch owner, we, addr and wdata, then go to ACCESS.
REQ-021 In ACCESS, the arbiter SHALL drive mem_en=1, and mem_we/mem_addr/mem_wdata from the latched values, for exactly one cycle, then go to RESP.
REQ-022 In RESP, the arbiter SHALL pulse the owner's rN_rvalid for one cycle, with rN_rdata=mem_rdata for loads, return to IDLE, and assert no ready in that cycle.
REQ-023 Latency SHALL be: acceptance at cycle T, mem_en at T+1, rvalid at T+2, next acceptance no earlier than T+3.
REQ-024 A request with addr[1:0] != 0 SHALL be accepted, SHALL produce no mem_en, and SHALL complete in RESP with rN_err=1 and rN_rdata=0.
REQ-025 Stores SHALL complete with rN_rvalid=1, rN_err=0 and rN_rdata=0.
REQ-026 Requesters SHALL hold valid and payload stable until ready; the arbiter samples the payload only in the acceptance cycle.
REQ-027 Outside ACCESS, mem_en and mem_we SHALL be 0; mem_addr and mem_wdata SHALL hold the last latched values.
REQ-028 The non-owner's rvalid, rdata and err SHALL remain 0.

Reset
REQ-029 reset=0 SHALL immediately force: state=IDLE; all rN_ready, rN_rvalid, rN_err, mem_en and mem_we to 0; rN_rdata, mem_addr and mem_wdata to 0; last-grant register to 1.
REQ-030 Reset during ACCESS or RESP SHALL abandon the transaction; no completion pulse is issued for it after reset release.
REQ-031 The first acceptance SHALL occur no earlier than the first rising edge after reset returns to 1.

Configuration
REQ-032 With macro DMEM_ARB_ROUND_ROBIN_EN defined, the arbiter SHALL resolve simultaneous valid requests in favour of the requester not granted last, and SHALL update the last-grant register on every acceptance.
REQ-033 With DMEM_ARB_ROUND_ROBIN_EN undefined, requester 0 SHALL always win ties, and the last-grant register SHALL be absent.
REQ-034 A single valid requester SHALL win in both modes.

Verification
REQ-035 r0 load, addr 0x8, memory word 2 = 0xDEADBEEF -> r0_ready at T, mem_en with mem_addr=0x8 at T+1, r0_rvalid with r0_rdata=0xDEADBEEF at T+2.
REQ-036 r1 store, addr 0x10, data 0x12345678 -> mem_en=1, mem_we=1, mem_addr=0x10, mem_wdata=0x12345678 at T+1; r1_rvalid=1, r1_err=0 at T+2.
REQ-037 Both requesters valid continuously for 4 transactions -> round-robin grants 0,1,0,1; fixed-priority grants 0,0,0,0 and r1_ready stays 0.
REQ-038 r0 load at addr 0x6 -> no mem_en; r0_rvalid=1, r0_err=1, r0_rdata=0 at T+2.
REQ-039 reset=0 asserted in the ACCESS cycle -> mem_en drops immediately; no rvalid is issued; after release, the next r0 request completes normally with 3-cycle spacing.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Two-requester data-memory arbiter: accept at T, memory strobe at T+1, completion at T+2, next accept from T+3.
// Define DMEM_ARB_ROUND_ROBIN_EN for round-robin tie-breaking; otherwise requester 0 has fixed priority.
module dmem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              r0_valid,
  output logic              r0_ready,
  input  logic              r0_we,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [DATA_W-1:0] r0_wdata,
  output logic              r0_rvalid,
  output logic [DATA_W-1:0] r0_rdata,
  output logic              r0_err,
  input  logic              r1_valid,
  output logic              r1_ready,
  input  logic              r1_we,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [DATA_W-1:0] r1_wdata,
  output logic              r1_rvalid,
  output logic [DATA_W-1:0] r1_rdata,
  output logic              r1_err,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t            state_q, state_d;
  logic              owner_q, owner_d;
  logic              we_q, we_d;
  logic              misalign_q, misalign_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
  logic              last_q, last_d;
`endif

  logic grant0, grant1;
  logic resp_vld;
  logic [DATA_W-1:0] rdata_sel;

  // Grants are combinational in IDLE and masked while reset is asserted.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state_q == IDLE && reset) begin
`ifdef DMEM_ARB_ROUND_ROBIN_EN
      if (r0_valid && r1_valid) begin
        grant0 = last_q;
        grant1 = !last_q;
      end else begin
        grant0 = r0_valid;
        grant1 = r1_valid;
      end
`else
      grant0 = r0_valid;
      grant1 = r1_valid && !r0_valid;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    we_d       = we_q;
    misalign_d = misalign_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
    last_d     = last_q;
`endif
    case (state_q)
      IDLE: begin
        if (grant0 || grant1) begin
          owner_d    = grant1;
          we_d       = grant1 ? r1_we    : r0_we;
          addr_d     = grant1 ? r1_addr  : r0_addr;
          wdata_d    = grant1 ? r1_wdata : r0_wdata;
          misalign_d = (addr_d[1:0] != 2'b00);
`ifdef DMEM_ARB_ROUND_ROBIN_EN
          last_d     = grant1;
`endif
          state_d    = ACCESS;
        end
      end
      ACCESS:  state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      owner_q    <= 1'b0;
      we_q       <= 1'b0;
      misalign_q <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
      last_q     <= 1'b1;
`endif
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      we_q       <= we_d;
      misalign_q <= misalign_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
      last_q     <= last_d;
`endif
    end
  end

  assign r0_ready = grant0;
  assign r1_ready = grant1;

  // A misaligned access still walks through ACCESS so completion timing is uniform.
  assign mem_en    = (state_q == ACCESS) && !misalign_q;
  assign mem_we    = mem_en && we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

  assign resp_vld  = (state_q == RESP);
  assign rdata_sel = (resp_vld && !we_q && !misalign_q) ? mem_rdata : '0;

  assign r0_rvalid = resp_vld && !owner_q;
  assign r1_rvalid = resp_vld && owner_q;
  assign r0_rdata  = r0_rvalid ? rdata_sel : '0;
  assign r1_rdata  = r1_rvalid ? rdata_sel : '0;
  assign r0_err    = r0_rvalid && misalign_q;
  assign r1_err    = r1_rvalid && misalign_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a small word-addressed memory behind the memory port.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        r0_valid = 1'b0, r0_we = 1'b0;
  logic [31:0] r0_addr = '0, r0_wdata = '0;
  logic        r1_valid = 1'b0, r1_we = 1'b0;
  logic [31:0] r1_addr = '0, r1_wdata = '0;
  logic        r0_ready, r0_rvalid, r0_err, r1_ready, r1_rvalid, r1_err;
  logic [31:0] r0_rdata, r1_rdata;
  logic        mem_en, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic [31:0] mem [0:15];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .reset(reset),
    .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_we(r0_we), .r0_addr(r0_addr),
    .r0_wdata(r0_wdata), .r0_rvalid(r0_rvalid), .r0_rdata(r0_rdata), .r0_err(r0_err),
    .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_we(r1_we), .r1_addr(r1_addr),
    .r1_wdata(r1_wdata), .r1_rvalid(r1_rvalid), .r1_rdata(r1_rdata), .r1_err(r1_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  // Synchronous memory: read data appears the cycle after the strobe.
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr[5:2]] <= mem_wdata;
      else        mem_rdata <= mem[mem_addr[5:2]];
    end
  end

  task automatic test_reset();
    r0_valid = 1'b1;
    r1_valid = 1'b1;
    #1;
    checks++; if ({r0_ready, r1_ready} !== 2'b00) begin errors++; $display("FAIL reset_ready got %b exp 00", {r0_ready, r1_ready}); end
    checks++; if ({mem_en, mem_we} !== 2'b00) begin errors++; $display("FAIL reset_mem_en_we got %b exp 00", {mem_en, mem_we}); end
    checks++; if (mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin errors++; $display("FAIL reset_mem_addr_wdata got %h %h exp 0 0", mem_addr, mem_wdata); end
    checks++; if ({r0_rvalid, r1_rvalid, r0_err, r1_err} !== 4'b0000) begin errors++; $display("FAIL reset_resp got %b exp 0000", {r0_rvalid, r1_rvalid, r0_err, r1_err}); end
    checks++; if (r0_rdata !== 32'h0 || r1_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got %h %h exp 0 0", r0_rdata, r1_rdata); end
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    checks++; if ({r0_ready, r1_ready, mem_en} !== 3'b000) begin errors++; $display("FAIL reset_held got %b exp 000", {r0_ready, r1_ready, mem_en}); end
    r0_valid = 1'b0;
    r1_valid = 1'b0;
    reset = 1'b1;
  endtask

  task automatic test_load();
    @(negedge clk); r0_valid = 1'b1; r0_we = 1'b0; r0_addr = 32'h8; #1;
    checks++; if ({r0_ready, r1_ready} !== 2'b10) begin errors++; $display("FAIL load_ready got %b exp 10", {r0_ready, r1_ready}); end
    @(negedge clk); r0_valid = 1'b0; r0_addr = 32'h0; #1;
    checks++; if ({mem_en, mem_we} !== 2'b10) begin errors++; $display("FAIL load_mem_en_we got %b exp 10", {mem_en, mem_we}); end
    checks++; if (mem_addr !== 32'h8) begin errors++; $display("FAIL load_mem_addr got %h exp 00000008", mem_addr); end
    checks++; if (r0_rvalid !== 1'b0) begin errors++; $display("FAIL load_early_rvalid got %b exp 0", r0_rvalid); end
    @(negedge clk); #1;
    checks++; if ({r0_rvalid, r0_err, r1_rvalid} !== 3'b100) begin errors++; $display("FAIL load_resp got %b exp 100", {r0_rvalid, r0_err, r1_rvalid}); end
    checks++; if (r0_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL load_rdata got %h exp deadbeef", r0_rdata); end
    checks++; if (mem_en !== 1'b0 || r1_rdata !== 32'h0) begin errors++; $display("FAIL load_resp_quiet got %b %h exp 0 0", mem_en, r1_rdata); end
    @(negedge clk); #1;
    checks++; if (r0_rvalid !== 1'b0) begin errors++; $display("FAIL load_pulse_len got %b exp 0", r0_rvalid); end
  endtask

  task automatic test_store();
    @(negedge clk); r1_valid = 1'b1; r1_we = 1'b1; r1_addr = 32'h10; r1_wdata = 32'h12345678; #1;
    checks++; if ({r0_ready, r1_ready} !== 2'b01) begin errors++; $display("FAIL store_ready got %b exp 01", {r0_ready, r1_ready}); end
    @(negedge clk); r1_valid = 1'b0; r1_addr = 32'h0; r1_wdata = 32'h0; #1;
    checks++; if ({mem_en, mem_we} !== 2'b11) begin errors++; $display("FAIL store_mem_en_we got %b exp 11", {mem_en, mem_we}); end
    checks++; if (mem_addr !== 32'h10 || mem_wdata !== 32'h12345678) begin errors++; $display("FAIL store_mem_payload got %h %h exp 00000010 12345678", mem_addr, mem_wdata); end
    @(negedge clk); #1;
    checks++; if ({r1_rvalid, r1_err, r0_rvalid} !== 3'b100) begin errors++; $display("FAIL store_resp got %b exp 100", {r1_rvalid, r1_err, r0_rvalid}); end
    checks++; if (r1_rdata !== 32'h0 || r0_rdata !== 32'h0) begin errors++; $display("FAIL store_rdata got %h %h exp 0 0", r1_rdata, r0_rdata); end
    @(negedge clk); #1;
    checks++; if ({mem_en, mem_we} !== 2'b00 || mem_addr !== 32'h10 || mem_wdata !== 32'h12345678) begin
      errors++; $display("FAIL store_hold got %b %h %h exp 00 00000010 12345678", {mem_en, mem_we}, mem_addr, mem_wdata);
    end
  endtask

  task automatic test_arbitration();
    int g = 0;
    int exp_g;
    int prev_g = 0;
    @(negedge clk);
    r0_valid = 1'b1; r0_we = 1'b0; r0_addr = 32'h0;
    r1_valid = 1'b1; r1_we = 1'b0; r1_addr = 32'h4;
    for (int c = 0; c < 12; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      if (r0_ready || r1_ready) begin
`ifdef DMEM_ARB_ROUND_ROBIN_EN
        exp_g = g % 2;
`else
        exp_g = 0;
`endif
        checks++; if (c != g * 3) begin errors++; $display("FAIL arb_grant_cycle got %0d exp %0d", c, g * 3); end
        checks++; if ({r1_ready, r0_ready} !== ((exp_g == 1) ? 2'b10 : 2'b01)) begin
          errors++; $display("FAIL arb_grant_%0d got r1r0=%b exp requester %0d", g, {r1_ready, r0_ready}, exp_g);
        end
        prev_g = exp_g;
        g++;
      end
      if (c % 3 == 2) begin
        checks++; if ({r1_rvalid, r0_rvalid} !== ((prev_g == 1) ? 2'b10 : 2'b01)) begin
          errors++; $display("FAIL arb_rvalid_c%0d got r1r0=%b exp owner %0d", c, {r1_rvalid, r0_rvalid}, prev_g);
        end
      end
    end
    checks++; if (g != 4) begin errors++; $display("FAIL arb_grant_count got %0d exp 4", g); end
    @(negedge clk); r0_valid = 1'b0; r1_valid = 1'b0;
  endtask

  task automatic test_misaligned();
    @(negedge clk); r0_valid = 1'b1; r0_we = 1'b0; r0_addr = 32'h6; #1;
    checks++; if (r0_ready !== 1'b1) begin errors++; $display("FAIL mis_ready got %b exp 1", r0_ready); end
    @(negedge clk); r0_valid = 1'b0; #1;
    checks++; if ({mem_en, mem_we} !== 2'b00) begin errors++; $display("FAIL mis_no_mem_en got %b exp 00", {mem_en, mem_we}); end
    @(negedge clk); #1;
    checks++; if ({r0_rvalid, r0_err, r1_rvalid, r1_err} !== 4'b1100) begin errors++; $display("FAIL mis_resp got %b exp 1100", {r0_rvalid, r0_err, r1_rvalid, r1_err}); end
    checks++; if (r0_rdata !== 32'h0) begin errors++; $display("FAIL mis_rdata got %h exp 0", r0_rdata); end
  endtask

  task automatic test_reset_access();
    @(negedge clk); r0_valid = 1'b1; r0_we = 1'b0; r0_addr = 32'h8; #1;
    checks++; if (r0_ready !== 1'b1) begin errors++; $display("FAIL rst_acc_ready got %b exp 1", r0_ready); end
    @(negedge clk); r0_valid = 1'b0; #1;
    checks++; if (mem_en !== 1'b1) begin errors++; $display("FAIL rst_acc_mem_en got %b exp 1", mem_en); end
    reset = 1'b0; #1;
    checks++; if ({mem_en, mem_we, r0_rvalid} !== 3'b000 || mem_addr !== 32'h0) begin
      errors++; $display("FAIL rst_acc_drop got %b %h exp 000 0", {mem_en, mem_we, r0_rvalid}, mem_addr);
    end
    @(negedge clk); reset = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); #1;
      checks++; if ({r0_rvalid, r1_rvalid, mem_en} !== 3'b000) begin errors++; $display("FAIL rst_acc_quiet_%0d got %b exp 000", c, {r0_rvalid, r1_rvalid, mem_en}); end
    end
    // Hold r0 valid across two loads to observe the 3-cycle spacing.
    @(negedge clk); r0_valid = 1'b1; r0_addr = 32'hC; #1;
    checks++; if (r0_ready !== 1'b1) begin errors++; $display("FAIL post_rst_ready got %b exp 1", r0_ready); end
    @(negedge clk); #1;
    checks++; if (mem_en !== 1'b1 || mem_addr !== 32'hC || r0_ready !== 1'b0) begin
      errors++; $display("FAIL post_rst_access got %b %h %b exp 1 0000000c 0", mem_en, mem_addr, r0_ready);
    end
    @(negedge clk); #1;
    checks++; if ({r0_rvalid, r0_err, r0_ready} !== 3'b100 || r0_rdata !== 32'hCAFEF00D) begin
      errors++; $display("FAIL post_rst_resp got %b %h exp 100 cafef00d", {r0_rvalid, r0_err, r0_ready}, r0_rdata);
    end
    @(negedge clk); #1;
    checks++; if (r0_ready !== 1'b1) begin errors++; $display("FAIL post_rst_spacing got %b exp 1", r0_ready); end
    @(negedge clk); r0_valid = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 32'h1000_0000 + i;
    mem[2] = 32'hDEADBEEF;
    mem[3] = 32'hCAFEF00D;
    test_reset();
    test_load();
    test_store();
    test_arbitration();
    test_misaligned();
    test_reset_access();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
